spi_burst_ctrl: RTL and testbench

Burst sequencer directly upstream of `spi_interface`. It accepts a byte-count command, streams bytes from an internal TX FIFO into `spi_interface` as one continuous chip-select transfer, and captures every received MISO byte into an internal RX FIFO. It owns the `byte_2_send`/`ena_spi` side of the byte handshake so host logic deals only with FIFOs and a command port.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_byte_fifo.sv | 50 +++++
 rtl/spi_burst_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_burst_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI burst sequencer: byte type and burst FSM states.
package spi_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    WAIT_END
  } burst_state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through head and full/empty flags.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_wr;
  logic        do_rd;

  // A push on a full FIFO and a pop on an empty one are ignored; an empty
  // FIFO is never bypassed, so a same-cycle push and pop only performs the push.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer feeding spi_interface from a TX FIFO and capturing MISO
// bytes into an RX FIFO, one continuous chip-select window per command.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             tx_wr,
  input  logic [7:0]       tx_data,
  output logic             tx_full,
  input  logic             rx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_empty,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             tx_unf,
  output logic             rx_ovf,
  input  logic             err_clr,
  output logic [7:0]       byte_2_send,
  output logic             ena_spi,
  input  logic [7:0]       byte_received,
  input  logic             new_byte,
  input  logic             end_trans
);

  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  burst_state_t     state_reg, state_next;
  byte_t            byte_2_send_reg, byte_2_send_next;
  logic             ena_spi_reg, ena_spi_next;
  logic             done_reg, done_next;
  logic             tx_unf_reg, tx_unf_next;
  logic             rx_ovf_reg, rx_ovf_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] to_start_reg, to_start_next;
  logic [LEN_W-1:0] to_rx_reg, to_rx_next;

  logic  len_ok;
  logic  tx_load;
  logic  tx_pop;
  logic  tx_empty;
  byte_t tx_head;
  logic  rx_push;
  logic  rx_full;

  spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .wr_en   (tx_wr),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .wr_en   (rx_push),
    .wr_data (byte_received),
    .rd_en   (rx_rd),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign len_ok = (cmd_len != '0) && (cmd_len <= MAX_LEN);

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    byte_2_send_next = byte_2_send_reg;
    ena_spi_next     = ena_spi_reg;
    done_next        = 1'b0;
    len_next         = len_reg;
    to_start_next    = to_start_reg;
    to_rx_next       = to_rx_reg;
    tx_load          = 1'b0;
    rx_push          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && len_ok) begin
          len_next     = cmd_len;
          tx_load      = 1'b1;
          ena_spi_next = 1'b1;
          state_next   = LAUNCH;
        end
      end
      LAUNCH: begin
        // Downstream latches byte 0 on this edge; stage byte 1 only if it exists.
        to_start_next = len_reg - ONE;
        to_rx_next    = len_reg;
        if (len_reg > ONE) begin
          tx_load    = 1'b1;
          state_next = RUN;
        end else begin
          ena_spi_next = 1'b0;
          state_next   = WAIT_END;
        end
      end
      RUN: begin
        if (new_byte) begin
          rx_push       = 1'b1;
          to_start_next = to_start_reg - ONE;
          if (to_start_reg > ONE) begin
            tx_load = 1'b1;
          end else begin
            ena_spi_next = 1'b0;
            state_next   = WAIT_END;
          end
        end
      end
      WAIT_END: begin
        if (end_trans) begin
          rx_push    = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (new_byte) begin
          rx_push = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (tx_load) byte_2_send_next = tx_empty ? 8'h00 : tx_head;
    if (rx_push) to_rx_next = (to_rx_reg != '0) ? (to_rx_reg - ONE) : '0;
  end

  assign tx_pop = tx_load && !tx_empty;

  // A new error in the same cycle as err_clr keeps the flag set.
  assign tx_unf_next = (tx_load && tx_empty) || (tx_unf_reg && !err_clr);
  assign rx_ovf_next = (rx_push && rx_full) || (rx_ovf_reg && !err_clr);

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      byte_2_send_reg <= 8'h00;
      ena_spi_reg     <= 1'b0;
      done_reg        <= 1'b0;
      tx_unf_reg      <= 1'b0;
      rx_ovf_reg      <= 1'b0;
      len_reg         <= '0;
      to_start_reg    <= '0;
      to_rx_reg       <= '0;
    end else begin
      byte_2_send_reg <= byte_2_send_next;
      ena_spi_reg     <= ena_spi_next;
      done_reg        <= done_next;
      tx_unf_reg      <= tx_unf_next;
      rx_ovf_reg      <= rx_ovf_next;
      len_reg         <= len_next;
      to_start_reg    <= to_start_next;
      to_rx_reg       <= to_rx_next;
    end
  end

  assign byte_2_send = byte_2_send_reg;
  assign ena_spi     = ena_spi_reg;
  assign done        = done_reg;
  assign tx_unf      = tx_unf_reg;
  assign rx_ovf      = rx_ovf_reg;
  assign busy        = (state_reg != IDLE);
  assign cmd_ready   = (state_reg == IDLE);

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: spi_interface slave agent, queue-based FIFO/burst model, directed bursts.
module tb_spi_burst_ctrl;
  import spi_pkg::*;

  localparam int DEPTH    = 16;
  localparam int LEN_W    = 5;
  localparam int BYTE_CYC = 6;

  logic             clk = 1'b0;
  logic             arstn = 1'b1;
  logic             tx_wr = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_full;
  logic             rx_rd = 1'b0;
  logic [7:0]       rx_data;
  logic             rx_empty;
  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_ready;
  logic             busy;
  logic             done;
  logic             tx_unf;
  logic             rx_ovf;
  logic             err_clr = 1'b0;
  logic [7:0]       byte_2_send;
  logic             ena_spi;
  logic [7:0]       byte_received = 8'h00;
  logic             new_byte = 1'b0;
  logic             end_trans = 1'b0;

  always #5 clk = ~clk;

  spi_burst_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .arstn         (arstn),
    .tx_wr         (tx_wr),
    .tx_data       (tx_data),
    .tx_full       (tx_full),
    .rx_rd         (rx_rd),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .cmd_valid     (cmd_valid),
    .cmd_len       (cmd_len),
    .cmd_ready     (cmd_ready),
    .busy          (busy),
    .done          (done),
    .tx_unf        (tx_unf),
    .rx_ovf        (rx_ovf),
    .err_clr       (err_clr),
    .byte_2_send   (byte_2_send),
    .ena_spi       (ena_spi),
    .byte_received (byte_received),
    .new_byte      (new_byte),
    .end_trans     (end_trans)
  );

  int checks = 0;
  int failures = 0;

  // Model state: FIFO contents as queues, sticky flags, slave agent records.
  byte_t m_tx[$];
  byte_t m_rx[$];
  byte_t slave_q[$];
  byte_t mosi_q[$];
  byte_t exp_mosi[$];
  bit    m_unf = 1'b0;
  bit    m_ovf = 1'b0;
  bit    exp_done = 1'b0;
  bit    chk_en = 1'b0;
  bit    agent_active = 1'b0;
  int    agent_cnt = 0;
  int    done_cnt = 0, ena_cnt = 0, nb_cnt = 0, et_cnt = 0, cs_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int mosi_at(input int i);
    if (i < mosi_q.size()) return int'(mosi_q[i]);
    return 'h1FF;
  endfunction

  // spi_interface stand-in: start on ena_spi while idle, BYTE_CYC cycles per byte.
  initial begin
    forever begin
      @(negedge clk);
      new_byte  = 1'b0;
      end_trans = 1'b0;
      exp_done  = 1'b0;
      if (arstn) begin
        agent_active = 1'b0;
        agent_cnt    = 0;
      end else if (!agent_active) begin
        if (ena_spi) begin
          agent_active = 1'b1;
          agent_cnt    = 0;
          mosi_q.push_back(byte_2_send);
          cs_cnt++;
        end
      end else begin
        agent_cnt++;
        if (agent_cnt == BYTE_CYC) begin
          if (slave_q.size() > 0) byte_received = slave_q.pop_front();
          else                    byte_received = 8'hEE;
          if (m_rx.size() < DEPTH) m_rx.push_back(byte_received);
          else                     m_ovf = 1'b1;
          if (ena_spi) begin
            new_byte = 1'b1;
            mosi_q.push_back(byte_2_send);
            agent_cnt = 0;
            nb_cnt++;
          end else begin
            end_trans    = 1'b1;
            exp_done     = 1'b1;
            agent_active = 1'b0;
            et_cnt++;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check("rx_empty", rx_empty, m_rx.size() == 0);
        check("rx_data", rx_data, (m_rx.size() > 0) ? int'(m_rx[0]) : 0);
        check("rx_ovf", rx_ovf, m_ovf);
        check("done", done, exp_done);
        check("ready_vs_busy", cmd_ready, !busy);
        if (!busy) begin
          check("ena_idle", ena_spi, 0);
          check("tx_full", tx_full, m_tx.size() == DEPTH);
          check("tx_unf", tx_unf, m_unf);
        end
        if (done) done_cnt++;
        if (ena_spi) ena_cnt++;
      end
    end
  end

  task automatic push_tx(input byte_t d);
    @(negedge clk);
    tx_wr = 1'b1;
    tx_data = d;
    if (m_tx.size() < DEPTH) m_tx.push_back(d);
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    @(negedge clk);
    rx_rd = 1'b1;
    if (m_rx.size() > 0) void'(m_rx.pop_front());
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    m_unf = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic run_burst(input int n);
    int base_cs;
    int waited;
    exp_mosi.delete();
    mosi_q.delete();
    base_cs = cs_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = n[LEN_W-1:0];
    for (int i = 0; i < n; i++) begin
      if (m_tx.size() > 0) exp_mosi.push_back(m_tx.pop_front());
      else begin
        exp_mosi.push_back(8'h00);
        m_unf = 1'b1;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("burst_timeout", waited < 2000, 1);
    @(negedge clk);
    check("cs_windows", cs_cnt - base_cs, 1);
    check("mosi_count", mosi_q.size(), n);
    for (int i = 0; i < n; i++) check($sformatf("mosi_byte%0d", i), mosi_at(i), exp_mosi[i]);
  endtask

  task automatic bad_cmd(input int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = n[LEN_W-1:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bad%0d_busy", n), busy, 0);
      check($sformatf("bad%0d_ena", n), ena_spi, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_2_send"}, byte_2_send, 8'h00);
    check({tag, "_ena_spi"}, ena_spi, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_tx_unf"}, tx_unf, 0);
    check({tag, "_rx_ovf"}, rx_ovf, 0);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_rx_empty"}, rx_empty, 1);
    check({tag, "_rx_data"}, rx_data, 8'h00);
  endtask

  initial begin
    int d0, e0, n0, t0, w;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    arstn  = 1'b0;
    chk_en = 1'b1;

    // 3-byte burst
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    slave_q = '{8'hA1, 8'hA2, 8'hA3};
    d0 = done_cnt;
    run_burst(3);
    $display("burst len=3 mosi=%02h %02h %02h", mosi_at(0), mosi_at(1), mosi_at(2));
    check("t1_mosi0", mosi_at(0), 8'h11);
    check("t1_mosi1", mosi_at(1), 8'h22);
    check("t1_mosi2", mosi_at(2), 8'h33);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_tx_unf", tx_unf, 0);
    check("t1_rx0", rx_data, 8'hA1); pop_rx();
    check("t1_rx1", rx_data, 8'hA2); pop_rx();
    check("t1_rx2", rx_data, 8'hA3); pop_rx();
    check("t1_rx_empty", rx_empty, 1);

    // single-byte burst
    push_tx(8'h5A);
    slave_q = '{8'h3C};
    e0 = ena_cnt; n0 = nb_cnt; t0 = et_cnt;
    run_burst(1);
    $display("burst len=1 mosi=%02h rx=%02h", mosi_at(0), rx_data);
    check("t2_ena_cycles", ena_cnt - e0, 1);
    check("t2_new_byte", nb_cnt - n0, 0);
    check("t2_end_trans", et_cnt - t0, 1);
    check("t2_mosi0", mosi_at(0), 8'h5A);
    check("t2_rx", rx_data, 8'h3C);
    pop_rx();

    // full-depth burst, RX left unread, then an overflowing burst
    for (int i = 0; i < DEPTH; i++) push_tx(byte_t'(i));
    check("t3_tx_full", tx_full, 1);
    for (int i = 0; i < DEPTH; i++) slave_q.push_back(byte_t'(8'h80 + i));
    run_burst(DEPTH);
    $display("burst len=16 mosi0=%02h mosi15=%02h rx_ovf=%0d", mosi_at(0), mosi_at(15), rx_ovf);
    check("t3_mosi15", mosi_at(15), 8'h0F);
    check("t3_rx_ovf", rx_ovf, 0);
    check("t3_rx_head", rx_data, 8'h80);
    push_tx(8'h77);
    slave_q = '{8'h99};
    run_burst(1);
    $display("burst len=1 into full RX rx_ovf=%0d", rx_ovf);
    check("t3_rx_ovf_set", rx_ovf, 1);
    check("t3_rx_head_kept", rx_data, 8'h80);
    for (int i = 0; i < DEPTH; i++) pop_rx();
    check("t3_rx_drained", rx_empty, 1);
    clear_err();
    check("t3_rx_ovf_clr", rx_ovf, 0);

    // underflow: 4-byte burst with 2 bytes loaded
    push_tx(8'hC0); push_tx(8'hC1);
    slave_q = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
    run_burst(4);
    $display("burst len=4 mosi=%02h %02h %02h %02h tx_unf=%0d",
             mosi_at(0), mosi_at(1), mosi_at(2), mosi_at(3), tx_unf);
    check("t4_mosi0", mosi_at(0), 8'hC0);
    check("t4_mosi1", mosi_at(1), 8'hC1);
    check("t4_mosi2", mosi_at(2), 8'h00);
    check("t4_mosi3", mosi_at(3), 8'h00);
    check("t4_tx_unf", tx_unf, 1);
    repeat (5) @(negedge clk);
    check("t4_tx_unf_sticky", tx_unf, 1);
    clear_err();
    check("t4_tx_unf_clr", tx_unf, 0);
    for (int i = 0; i < 4; i++) pop_rx();

    // illegal lengths
    bad_cmd(0);
    bad_cmd(17);
    $display("illegal cmd_len 0 and 17 issued busy=%0d ena_spi=%0d", busy, ena_spi);

    // reset in the middle of byte 2 of a 5-byte burst
    for (int i = 0; i < 5; i++) push_tx(byte_t'(8'h10 + i));
    slave_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    mosi_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 5'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (mosi_q.size() < 3 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("t6_wait_byte2", w < 500, 1);
    check("t6_busy_before", busy, 1);
    repeat (2) @(negedge clk);
    #2;
    chk_en = 1'b0;
    arstn  = 1'b1;
    #1;
    check_reset_values("mid_rst");
    $display("reset asserted mid-burst ena_spi=%0d busy=%0d", ena_spi, busy);
    repeat (2) @(negedge clk);
    m_tx.delete(); m_rx.delete(); slave_q.delete(); mosi_q.delete();
    m_unf = 1'b0;
    m_ovf = 1'b0;
    arstn  = 1'b0;
    chk_en = 1'b1;
    push_tx(8'hC5); push_tx(8'hC6);
    slave_q = '{8'hE1, 8'hE2};
    run_burst(2);
    $display("burst len=2 after reset mosi=%02h %02h", mosi_at(0), mosi_at(1));
    check("t6_mosi0", mosi_at(0), 8'hC5);
    check("t6_mosi1", mosi_at(1), 8'hC6);
    check("t6_rx0", rx_data, 8'hE1); pop_rx();
    check("t6_rx1", rx_data, 8'hE2); pop_rx();
    check("t6_rx_empty", rx_empty, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
